// File: rtl/mod_counter_sched.sv
// mod_counter_sched
// Shares one external mod_counter between NUM_REQ requesters. Each accepted
// job runs LOAD (one load strobe), then RUN (len count-enable cycles, or fewer
// if aborted), then DONE (one-cycle completion pulse with the final value).
//
// Ports
//   clk, resetn             rising-edge clock, asynchronous active-low reset
//   req_valid / req_ready   per-requester handshake; ready is one-hot, IDLE only
//   req_mode/data/len       per-requester job payload (slice i = requester i)
//   abort                   ends RUN early, ignored in other states
//   cnt_load/en/mode/data   control to the shared counter
//   cnt_q                   counter value fed back
//   done                    one-hot completion pulse (DONE state)
//   result, wrap_cnt        final value and saturating wrap count of last job
//   busy                    high whenever a job is in flight
module mod_counter_sched #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 4,
  parameter int LEN_W   = 4,
  parameter int UP_MAX  = 11,
  parameter int DN_MAX  = 11
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_mode,
  input  logic [NUM_REQ*CNT_W-1:0] req_data,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic                     abort,
  output logic                     cnt_load,
  output logic                     cnt_en,
  output logic                     cnt_mode,
  output logic [CNT_W-1:0]         cnt_data,
  input  logic [CNT_W-1:0]         cnt_q,
  output logic [NUM_REQ-1:0]       done,
  output logic [CNT_W-1:0]         result,
  output logic [LEN_W-1:0]         wrap_cnt,
  output logic                     busy
);

  localparam int               PTR_W    = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] UP_LAST  = CNT_W'(UP_MAX);
  localparam logic [LEN_W-1:0] WRAP_SAT = '1;

  // The down-mode reload value lives inside the counter; it is only checked
  // here so a mismatched instantiation is caught at elaboration.
  generate
    if (NUM_REQ < 2 || UP_MAX >= (2 ** CNT_W) || DN_MAX >= (2 ** CNT_W)) begin : g_bad_params
      $error("mod_counter_sched: NUM_REQ must be >= 2 and UP_MAX/DN_MAX must fit in CNT_W bits");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   wrap_q, wrap_d;
  logic [CNT_W-1:0]   result_q, result_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   scan_idx;
  logic               found;
  logic               wrap_hit;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    pick_onehot = '0;
    pick        = '0;
    scan_idx    = '0;
    found       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found                 = 1'b1;
        pick                  = scan_idx;
        pick_onehot[scan_idx] = 1'b1;
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE) ? pick_onehot : '0;

  // Wrap is judged on the value the counter holds before this cycle's step.
  assign wrap_hit = mode_q ? (cnt_q == '0) : (cnt_q >= UP_LAST);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    mode_d   = mode_q;
    data_d   = data_q;
    rem_d    = rem_q;
    wrap_d   = wrap_q;
    result_d = result_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    done     = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d  = pick;
          mode_d   = req_mode[pick];
          data_d   = req_data[int'(pick)*CNT_W +: CNT_W];
          rem_d    = req_len[int'(pick)*LEN_W +: LEN_W];
          rr_ptr_d = PTR_W'((int'(pick) + 1) % NUM_REQ);
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_load = 1'b1;
        wrap_d   = '0;
        state_d  = (rem_q != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (abort) begin
          // No step this cycle; steps already taken stand.
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
          rem_d  = rem_q - LEN_W'(1);
          if (wrap_hit && wrap_q != WRAP_SAT) begin
            wrap_d = wrap_q + LEN_W'(1);
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done[owner_q] = 1'b1;
        result_d      = cnt_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      mode_q   <= 1'b0;
      data_q   <= '0;
      rem_q    <= '0;
      wrap_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      wrap_q   <= wrap_d;
      result_q <= result_d;
    end
  end

  assign cnt_mode = mode_q;
  assign cnt_data = data_q;
  assign result   = result_q;
  assign wrap_cnt = wrap_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod_counter_sched.sv
// Bench for mod_counter_sched: a behavioural mod-12 counter closes the loop,
// stimulus pushes expected job outcomes into a queue, and a monitor pops and
// compares them on each done pulse.
module tb_mod_counter_sched;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] req_valid, req_ready, req_mode;
  logic [7:0] req_data, req_len;
  logic       abort;
  logic       cnt_load, cnt_en, cnt_mode;
  logic [3:0] cnt_data, cnt_q;
  logic [1:0] done;
  logic [3:0] result, wrap_cnt;
  logic       busy;

  mod_counter_sched dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_data(req_data), .req_len(req_len), .abort(abort),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_mode(cnt_mode),
    .cnt_data(cnt_data), .cnt_q(cnt_q),
    .done(done), .result(result), .wrap_cnt(wrap_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counter being shared: up wraps 11->0, down reloads 11 after 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       cnt_q <= 4'd0;
    else if (cnt_load) cnt_q <= cnt_data;
    else if (cnt_en)   cnt_q <= cnt_mode ? ((cnt_q == 4'd0) ? 4'd11 : cnt_q - 4'd1)
                                         : ((cnt_q >= 4'd11) ? 4'd0 : cnt_q + 4'd1);
  end

  typedef struct {
    int req; int res; int wrap; int steps; int lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency is measured from the accept cycle to the done cycle;
  // result/wrap_cnt are checked the cycle after done, once result is captured.
  int   acc_cyc = 0, en_cnt = 0, load_cnt = 0;
  bit   pend = 0;
  exp_t pe;
  always @(negedge clk) begin
    if (!resetn) begin
      en_cnt = 0; load_cnt = 0; pend = 0;
      chk("done_in_reset", int'(done), 0);
    end else begin
      if (busy) chk("ready_while_busy", int'(req_ready), 0);
      if (cnt_en)   en_cnt++;
      if (cnt_load) load_cnt++;
      if (pend) begin
        chk("result", int'(result), pe.res);
        chk("wrap_cnt", int'(wrap_cnt), pe.wrap);
        $display("job req=%0d result=%0d wrap=%0d steps=%0d", pe.req, result, wrap_cnt, pe.steps);
        pend = 0;
      end
      if ((req_valid & req_ready) != 2'b00) begin
        acc_cyc = cyc; en_cnt = 0; load_cnt = 0;
      end
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          pe = sb.pop_front();
          chk("done_onehot", int'(done), 1 << pe.req);
          chk("latency", cyc - acc_cyc, pe.lat);
          chk("en_cycles", en_cnt, pe.steps);
          chk("load_cycles", load_cnt, 1);
          pend = 1;
        end
      end
    end
  end

  task automatic set_req(input int i, input bit mode, input int data, input int len);
    req_mode[i]          = mode;
    req_data[i*4 +: 4]   = 4'(data);
    req_len[i*4 +: 4]    = 4'(len);
  endtask

  // Single request; expectation pushed once the grant is seen.
  task automatic send(input int i, input bit mode, input int data, input int len,
                      input int r, input int w, input int st, input int lat);
    bit ok;
    exp_t e;
    @(posedge clk); #1;
    set_req(i, mode, data, len);
    req_valid[i] = 1'b1;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = req_ready[i];
    end
    if (ok) begin
      e = '{req: i, res: r, wrap: w, steps: st, lat: lat};
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    chk("accept_timeout", int'(ok), 1);
  endtask

  // Both requesters held valid until each has been granted n times.
  task automatic hold_both(input int n0, input int n1);
    int got0, got1;
    bit a0, a1;
    got0 = 0; got1 = 0;
    @(posedge clk); #1;
    req_valid = 2'b11;
    for (int c = 0; c < 500 && (got0 < n0 || got1 < n1); c++) begin
      @(negedge clk);
      a0 = req_valid[0] & req_ready[0];
      a1 = req_valid[1] & req_ready[1];
      @(posedge clk); #1;
      if (a0) begin got0++; if (got0 >= n0) req_valid[0] = 1'b0; end
      if (a1) begin got1++; if (got1 >= n1) req_valid[1] = 1'b0; end
    end
    req_valid = 2'b00;
    chk("grants_req0", got0, n0);
    chk("grants_req1", got1, n1);
  endtask

  initial begin
    resetn = 1'b0; req_valid = '0; req_mode = '0; req_data = '0; req_len = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_wrap", int'(wrap_cnt), 0);
    chk("rst_cnt_load", int'(cnt_load), 0);
    @(posedge clk); #1 resetn = 1'b1;

    // Plain up count, up wrap, down wrap, zero-length job.
    send(0, 1'b0, 3, 4, 7, 0, 4, 6);
    send(1, 1'b0, 10, 3, 1, 1, 3, 5);
    send(0, 1'b1, 1, 3, 10, 1, 3, 5);
    send(1, 1'b0, 9, 0, 9, 0, 0, 2);

    // Contention: rr_ptr is 0 here, so grants alternate starting at req0.
    set_req(0, 1'b0, 2, 2);
    set_req(1, 1'b1, 5, 2);
    for (int j = 0; j < 3; j++) begin
      sb.push_back('{req: 0, res: 4, wrap: 0, steps: 2, lat: 4});
      sb.push_back('{req: 1, res: 3, wrap: 0, steps: 2, lat: 4});
    end
    hold_both(3, 3);

    // Abort on the second RUN cycle: one step only.
    send(0, 1'b0, 5, 8, 6, 0, 1, 4);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;

    // Reset mid-RUN after a down wrap has been counted (rr_ptr is 1 now).
    send(0, 1'b1, 1, 8, 0, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    void'(sb.pop_back());
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cnt_en", int'(cnt_en), 0);
    chk("mid_rst_cnt_mode", int'(cnt_mode), 0);
    chk("mid_rst_cnt_data", int'(cnt_data), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_wrap", int'(wrap_cnt), 0);
    chk("mid_rst_done", int'(done), 0);
    set_req(1, 1'b1, 4, 1);
    sb.push_back('{req: 0, res: 5, wrap: 1, steps: 8, lat: 10});
    sb.push_back('{req: 1, res: 3, wrap: 0, steps: 1, lat: 3});
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    hold_both(1, 1);

    begin
      bit drained;
      drained = 0;
      for (int c = 0; c < 200 && !drained; c++) begin
        @(negedge clk);
        drained = (sb.size() == 0) && !pend;
      end
      chk("scoreboard_drained", int'(drained), 1);
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
